mvu_quantser: RTL and testbench

//  Per-MVU output quantizer/serializer, directly downstream of the scaler pipeline.

---
 rtl/mvu_quantser.sv | 144 ++++++++++++++
 tb/tb_mvu_quantser.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvu_quantser.sv
// mvu_quantser: per-MVU output quantizer/serializer.
// Latches one vector of N two's-complement scaler results and streams a
// window of its bit-planes, MSB first, as N-bit words for the data bank.
// Every output is registered. The next plane is computed one cycle ahead,
// so the first plane appears in the cycle after the vector is accepted.
module mvu_quantser #(
    parameter int N       = 64,
    parameter int BWIN    = 48,
    parameter int BMSBIDX = 6,
    parameter int BBWOUT  = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [N*BWIN-1:0]    i_data,
    input  logic [BMSBIDX-1:0]   i_msbidx,
    input  logic [BBWOUT-1:0]    i_bwout,
    output logic                 o_valid,
    output logic [N-1:0]         o_word,
    output logic                 o_first,
    output logic                 o_last
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [N*BWIN-1:0]   r_data;
    logic [BMSBIDX-1:0]  r_msb;
    logic [BBWOUT-1:0]   r_nlast;
    logic [BBWOUT-1:0]   r_k;

    logic                w_last;
    logic                w_accept;
    logic                w_emit_more;
    logic [N*BWIN-1:0]   w_src;
    logic [BMSBIDX-1:0]  w_msb;
    logic [BBWOUT-1:0]   w_nlast;
    logic [BBWOUT-1:0]   w_k;
    logic [N-1:0]        w_plane;

    // Requested MSB index clamped to the top bit of a lane.
    function automatic logic [BMSBIDX-1:0] clamp_msb(input logic [BMSBIDX-1:0] idx);
        if (int'(idx) > BWIN - 1)
            return BMSBIDX'(BWIN - 1);
        return idx;
    endfunction

    // Index of the final plane; a precision of 0 still emits one plane.
    function automatic logic [BBWOUT-1:0] last_idx(input logic [BBWOUT-1:0] bw);
        if (bw == '0)
            return '0;
        return bw - BBWOUT'(1);
    endfunction

    // Gather bit (msb-k) of every lane; positions below bit 0 read as zero.
    function automatic logic [N-1:0] bit_plane(input logic [N*BWIN-1:0] data,
                                               input logic [BMSBIDX-1:0] msb,
                                               input logic [BBWOUT-1:0]  k);
        logic [N-1:0]       w;
        logic [BWIN-1:0]    lane;
        logic [BMSBIDX-1:0] bidx;
        w    = '0;
        bidx = '0;
        if (int'(k) <= int'(msb))
            bidx = msb - BMSBIDX'(k);
        for (int i = 0; i < N; i++) begin
            lane = data[i*BWIN +: BWIN];
            if (int'(k) <= int'(msb))
                w[i] = lane[bidx];
        end
        return w;
    endfunction

    assign w_last      = (r_state == EMIT) && (r_k == r_nlast);
    assign i_ready     = (r_state == IDLE) || w_last;
    assign w_accept    = i_valid && i_ready;
    assign w_emit_more = (r_state == EMIT) && !w_last;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next state and the plane to present on the following cycle.
    always_comb begin
        w_next  = r_state;
        w_src   = r_data;
        w_msb   = r_msb;
        w_nlast = r_nlast;
        w_k     = r_k + BBWOUT'(1);
        if (w_accept) begin
            w_next  = EMIT;
            w_src   = i_data;
            w_msb   = clamp_msb(i_msbidx);
            w_nlast = last_idx(i_bwout);
            w_k     = '0;
        end else if (w_last) begin
            w_next  = IDLE;
        end
        w_plane = bit_plane(w_src, w_msb, w_k);
    end

    // Holding registers and plane counter; k tracks the plane on o_word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_msb   <= '0;
            r_nlast <= '0;
            r_k     <= '0;
        end else if (w_accept) begin
            r_data  <= i_data;
            r_msb   <= w_msb;
            r_nlast <= w_nlast;
            r_k     <= '0;
        end else if (w_emit_more) begin
            r_k     <= w_k;
        end
    end

    // Registered output word and framing flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_word  <= '0;
            o_first <= 1'b0;
            o_last  <= 1'b0;
        end else if (w_accept || w_emit_more) begin
            o_valid <= 1'b1;
            o_word  <= w_plane;
            o_first <= w_accept;
            o_last  <= (w_k == w_nlast);
        end else begin
            o_valid <= 1'b0;
            o_first <= 1'b0;
            o_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mvu_quantser.sv
// Testbench for mvu_quantser: directed vector table, hand-written
// back-to-back and reset sequences, and a randomized scoreboard phase.
module tb_mvu_quantser;

    localparam int N       = 64;
    localparam int BWIN    = 48;
    localparam int BMSBIDX = 6;
    localparam int BBWOUT  = 6;
    localparam int NRAND   = 300;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                i_valid = 1'b0;
    logic                i_ready;
    logic [N*BWIN-1:0]   i_data = '0;
    logic [BMSBIDX-1:0]  i_msbidx = '0;
    logic [BBWOUT-1:0]   i_bwout = '0;
    logic                o_valid;
    logic [N-1:0]        o_word;
    logic                o_first;
    logic                o_last;

    int n_chk  = 0;
    int n_pass = 0;
    bit run_rand = 1'b0;

    typedef struct {
        logic [47:0] l0;
        logic [47:0] l1;
        logic [5:0]  msb;
        logic [5:0]  bw;
        int          n;
        logic [15:0] exp;   // plane k expects {lane1,lane0} in bits [2k+1:2k]
    } vec_t;

    typedef struct {
        logic [N-1:0] w;
        logic         f;
        logic         l;
    } plane_t;

    plane_t sb[$];

    mvu_quantser #(.N(N), .BWIN(BWIN), .BMSBIDX(BMSBIDX), .BBWOUT(BBWOUT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .i_data   (i_data),
        .i_msbidx (i_msbidx),
        .i_bwout  (i_bwout),
        .o_valid  (o_valid),
        .o_word   (o_word),
        .o_first  (o_first),
        .o_last   (o_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic put(input logic [47:0] l0, input logic [47:0] l1,
                       input logic [5:0] msb, input logic [5:0] bw);
        i_data = '0;
        i_data[47:0]  = l0;
        i_data[95:48] = l1;
        i_msbidx = msb;
        i_bwout  = bw;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] ref_plane(input logic [N*BWIN-1:0] d, input int msbidx, input int k);
        logic [N-1:0] w;
        int m;
        int b;
        m = (msbidx > BWIN - 1) ? BWIN - 1 : msbidx;
        b = m - k;
        w = '0;
        if (b >= 0)
            for (int i = 0; i < N; i++)
                w[i] = d[i*BWIN + b];
        return w;
    endfunction

    // Scoreboard monitor for the random phase.
    always @(negedge clk) begin
        if (run_rand && rst_n && o_valid) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL rand_unexpected_plane: got word %0h, expected no plane", o_word);
            end else begin
                plane_t p;
                p = sb.pop_front();
                chk("rand_plane", {o_word, o_first, o_last}, {p.w, p.f, p.l});
            end
        end
    end

    initial begin
        vec_t tbl[6];
        bit   seen;
        int   waited;
        tbl[0] = '{48'h5,              48'h2,              6'd2,  6'd3, 3, 16'h0019};
        tbl[1] = '{48'h3,              48'h0,              6'd1,  6'd4, 4, 16'h0005};
        tbl[2] = '{48'h8000_0000_0000, 48'h0,              6'd63, 6'd0, 1, 16'h0001};
        tbl[3] = '{48'hFFFF_FFFF_FFFF, 48'h0000_0000_00F0, 6'd7,  6'd5, 5, 16'h01FF};
        tbl[4] = '{48'hA,              48'h5,              6'd3,  6'd4, 4, 16'h0099};
        tbl[5] = '{48'h4000_0000_0000, 48'h8000_0000_0000, 6'd50, 6'd2, 2, 16'h0006};

        // Reset state
        #12;
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_first", o_first, 0);
        chk("rst_o_last",  o_last,  0);
        chk("rst_o_word",  o_word,  0);
        chk("rst_i_ready", i_ready, 1);
        rst_n = 1'b1;
        tick();

        // Directed vector table
        for (int v = 0; v < 6; v++) begin
            put(tbl[v].l0, tbl[v].l1, tbl[v].msb, tbl[v].bw);
            i_valid = 1'b1;
            tick();
            i_valid = 1'b0;
            for (int k = 0; k < tbl[v].n; k++) begin
                logic [15:0] e;
                e = tbl[v].exp;
                chk($sformatf("v%0d_k%0d_valid", v, k), o_valid, 1);
                chk($sformatf("v%0d_k%0d_word", v, k), o_word, {62'd0, e[2*k +: 2]});
                chk($sformatf("v%0d_k%0d_first", v, k), o_first, (k == 0));
                chk($sformatf("v%0d_k%0d_last", v, k), o_last, (k == tbl[v].n - 1));
                chk($sformatf("v%0d_k%0d_ready", v, k), i_ready, (k == tbl[v].n - 1));
                if (k < tbl[v].n - 1)
                    tick();
            end
            tick();
            chk($sformatf("v%0d_idle_valid", v), o_valid, 0);
            chk($sformatf("v%0d_idle_flags", v), {o_first, o_last}, 2'b00);
        end

        // Back-to-back: A then B with i_valid held high, no bubble
        put(48'h5, 48'h0, 6'd2, 6'd2);
        i_valid = 1'b1;
        tick();
        put(48'h2, 48'h1, 6'd1, 6'd2);
        chk("b2b_c1", {o_valid, o_first, o_last, i_ready, o_word}, {4'b1100, 64'h1});
        tick();
        put(48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 6'd1, 6'd2);
        put(48'h2, 48'h1, 6'd1, 6'd2);
        chk("b2b_c2", {o_valid, o_first, o_last, i_ready, o_word}, {4'b1011, 64'h0});
        tick();
        i_valid = 1'b0;
        chk("b2b_c3", {o_valid, o_first, o_last, i_ready, o_word}, {4'b1100, 64'h1});
        tick();
        chk("b2b_c4", {o_valid, o_first, o_last, i_ready, o_word}, {4'b1011, 64'h2});
        tick();
        chk("b2b_c5", {o_valid, i_ready}, 2'b01);

        // Values offered while not ready are ignored: change data mid-vector
        put(48'h3, 48'h0, 6'd1, 6'd3);
        i_valid = 1'b1;
        tick();
        put(48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 6'd47, 6'd9);
        tick();
        i_valid = 1'b0;
        chk("ign_k1", {o_valid, o_last, o_word}, {2'b10, 64'h1});
        tick();
        chk("ign_k2", {o_valid, o_last, o_word}, {2'b11, 64'h0});
        tick();
        chk("ign_idle", o_valid, 0);

        // Reset mid-EMIT at plane k=2 of 4
        put(48'hF, 48'h0, 6'd3, 6'd4);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        tick();
        chk("mid_k2", {o_valid, o_first, o_last}, 3'b100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_ready", i_ready, 1);
        #10;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (o_valid) seen = 1'b1;
        end
        chk("mid_no_more_planes", seen, 0);
        chk("mid_ready_after", i_ready, 1);

        // Random vectors against the reference model
        run_rand = 1'b1;
        for (int v = 0; v < NRAND; v++) begin
            int gap;
            int msb;
            int bw;
            int n;
            bit got;
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                i_valid = 1'b0;
                for (int g = 0; g < gap; g++) tick();
            end
            for (int j = 0; j < N*BWIN/32; j++)
                i_data[j*32 +: 32] = $urandom;
            msb = $urandom_range(0, 63);
            bw  = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 6);
            i_msbidx = BMSBIDX'(msb);
            i_bwout  = BBWOUT'(bw);
            i_valid  = 1'b1;
            got    = 1'b0;
            waited = 0;
            while (!got && waited < 200) begin
                bit rdy;
                @(negedge clk);
                rdy = i_ready;
                tick();
                waited++;
                if (rdy) begin
                    got = 1'b1;
                    n = (bw == 0) ? 1 : bw;
                    for (int k = 0; k < n; k++) begin
                        plane_t p;
                        p.w = ref_plane(i_data, msb, k);
                        p.f = (k == 0);
                        p.l = (k == n - 1);
                        sb.push_back(p);
                    end
                end
            end
            if (!got) begin
                n_chk++;
                $display("FAIL rand_accept_timeout: vector %0d waited %0d cycles, expected acceptance", v, waited);
            end
        end
        i_valid = 1'b0;
        waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            tick();
            waited++;
        end
        tick();
        chk("rand_drained", sb.size(), 0);
        run_rand = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
